// File: rtl/sc_speedtimer_if.sv
// Bus between the speed counter and the speed timer: the period load controls going in,
// the count, tick and done status coming back.
interface sc_speedtimer_if #(
    parameter int unsigned SPEEDTIMER_DATAWIDTH = 8
) ();

    logic [SPEEDTIMER_DATAWIDTH-1:0] SC_SPEEDTIMER_data_InBUS;
    logic                            SC_SPEEDTIMER_load_InLow;
    logic                            SC_SPEEDTIMER_enable_InLow;
    logic                            SC_SPEEDTIMER_oneshot_InLow;
    logic [SPEEDTIMER_DATAWIDTH-1:0] SC_SPEEDTIMER_data_OutBUS;
    logic                            SC_SPEEDTIMER_tick_Out;
    logic                            SC_SPEEDTIMER_done_Out;

    modport master (
        output SC_SPEEDTIMER_data_InBUS,
        output SC_SPEEDTIMER_load_InLow,
        output SC_SPEEDTIMER_enable_InLow,
        output SC_SPEEDTIMER_oneshot_InLow,
        input  SC_SPEEDTIMER_data_OutBUS,
        input  SC_SPEEDTIMER_tick_Out,
        input  SC_SPEEDTIMER_done_Out
    );

    modport slave (
        input  SC_SPEEDTIMER_data_InBUS,
        input  SC_SPEEDTIMER_load_InLow,
        input  SC_SPEEDTIMER_enable_InLow,
        input  SC_SPEEDTIMER_oneshot_InLow,
        output SC_SPEEDTIMER_data_OutBUS,
        output SC_SPEEDTIMER_tick_Out,
        output SC_SPEEDTIMER_done_Out
    );

endinterface

// File: rtl/sc_speedtimer.sv
// Programmable down-counting timer: loads a period, counts it down while enabled and
// emits a registered one-cycle tick on expiry, then reloads (periodic) or stops (one-shot).
module sc_speedtimer #(
    parameter int unsigned SPEEDTIMER_DATAWIDTH = 8
) (
    input  logic           SC_SPEEDTIMER_CLOCK_50,
    input  logic           SC_SPEEDTIMER_RESET_InLow,
    sc_speedtimer_if.slave bus_io
);

    localparam logic [SPEEDTIMER_DATAWIDTH-1:0] CntZero = '0;
    localparam logic [SPEEDTIMER_DATAWIDTH-1:0] CntOne  = SPEEDTIMER_DATAWIDTH'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                          state_q, state_d;
    logic [SPEEDTIMER_DATAWIDTH-1:0] count_q, count_d;
    logic [SPEEDTIMER_DATAWIDTH-1:0] period_q, period_d;
    logic                            tick_q, tick_d;
    logic                            done_q, done_d;

    logic load, run_step, expire;

    assign load     = ~bus_io.SC_SPEEDTIMER_load_InLow;
    assign run_step = (state_q == StRun) && ~bus_io.SC_SPEEDTIMER_enable_InLow;
    // Only count==1 expires; count is never 0 in StRun because a zero load goes to StIdle.
    assign expire   = run_step && (count_q == CntOne);

    always_ff @(posedge SC_SPEEDTIMER_CLOCK_50 or negedge SC_SPEEDTIMER_RESET_InLow) begin
        if (!SC_SPEEDTIMER_RESET_InLow) begin
            state_q  <= StIdle;
            count_q  <= CntZero;
            period_q <= CntZero;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (bus_io.SC_SPEEDTIMER_data_InBUS != CntZero) ? StRun : StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StIdle;
                StRun:   if (expire && !bus_io.SC_SPEEDTIMER_oneshot_InLow) state_d = StDone;
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        tick_d   = 1'b0;
        done_d   = done_q;
        if (load) begin
            // Load wins over a coincident expiry, so that tick is dropped.
            period_d = bus_io.SC_SPEEDTIMER_data_InBUS;
            count_d  = bus_io.SC_SPEEDTIMER_data_InBUS;
            done_d   = 1'b0;
        end else if (expire) begin
            tick_d = 1'b1;
            if (bus_io.SC_SPEEDTIMER_oneshot_InLow) begin
                count_d = period_q;
            end else begin
                count_d = CntZero;
                done_d  = 1'b1;
            end
        end else if (run_step && (count_q > CntOne)) begin
            count_d = count_q - CntOne;
        end
    end

    assign bus_io.SC_SPEEDTIMER_data_OutBUS = count_q;
    assign bus_io.SC_SPEEDTIMER_tick_Out    = tick_q;
    assign bus_io.SC_SPEEDTIMER_done_Out    = done_q;

endmodule

// File: tb/tb_sc_speedtimer.sv
// Directed and randomized bench for sc_speedtimer against a cycle-level reference model.
module tb_sc_speedtimer;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;

    sc_speedtimer_if #(.SPEEDTIMER_DATAWIDTH(W)) bif ();

    sc_speedtimer #(.SPEEDTIMER_DATAWIDTH(W)) dut (
        .SC_SPEEDTIMER_CLOCK_50    (clk),
        .SC_SPEEDTIMER_RESET_InLow (rst_n),
        .bus_io                    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model: remaining enabled cycles to expiry, the loaded period and a phase.
    localparam int PhIdle = 0;
    localparam int PhRun  = 1;
    localparam int PhDone = 2;
    int m_left;
    int m_per;
    int m_phase;
    bit m_tick;

    task automatic model_reset();
        m_left  = 0;
        m_per   = 0;
        m_phase = PhIdle;
        m_tick  = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (!bif.SC_SPEEDTIMER_load_InLow) begin
            m_per   = int'(bif.SC_SPEEDTIMER_data_InBUS);
            m_left  = m_per;
            m_phase = (m_per == 0) ? PhIdle : PhRun;
            m_tick  = 1'b0;
        end else begin
            m_tick = 1'b0;
            if (m_phase == PhRun && !bif.SC_SPEEDTIMER_enable_InLow) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_tick = 1'b1;
                    if (bif.SC_SPEEDTIMER_oneshot_InLow) m_left = m_per;
                    else m_phase = PhDone;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(bif.SC_SPEEDTIMER_data_OutBUS), 32'(m_left));
        chk("tick", 32'(bif.SC_SPEEDTIMER_tick_Out), 32'(m_tick));
        chk("done", 32'(bif.SC_SPEEDTIMER_done_Out), 32'(m_phase == PhDone));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_load(input int v, input bit os_n);
        bif.SC_SPEEDTIMER_data_InBUS    = W'(v);
        bif.SC_SPEEDTIMER_oneshot_InLow = os_n;
        bif.SC_SPEEDTIMER_load_InLow    = 1'b0;
        step();
        bif.SC_SPEEDTIMER_load_InLow    = 1'b1;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int first_tick;
        rst_n                           = 1'b0;
        bif.SC_SPEEDTIMER_data_InBUS    = '0;
        bif.SC_SPEEDTIMER_load_InLow    = 1'b1;
        bif.SC_SPEEDTIMER_enable_InLow  = 1'b1;
        bif.SC_SPEEDTIMER_oneshot_InLow = 1'b1;
        model_reset();
        step();
        step();
        rst_n = 1'b1;

        // Reset mid-count, then idle with no load.
        bif.SC_SPEEDTIMER_enable_InLow = 1'b0;
        do_load(4, 1'b1);
        for (int i = 0; i < 2; i++) step();
        async_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_count", 32'(bif.SC_SPEEDTIMER_data_OutBUS), 32'd0);
            chk("idle_tick", 32'(bif.SC_SPEEDTIMER_tick_Out), 32'd0);
        end

        // Periodic N=4: tick every 4th edge after the load edge.
        do_load(4, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("per4_tick", 32'(bif.SC_SPEEDTIMER_tick_Out), 32'(k % 4 == 0));
            chk("per4_count", 32'(bif.SC_SPEEDTIMER_data_OutBUS), 32'(4 - (k % 4)));
        end

        // One-shot N=3, then done held, then reload clears done.
        do_load(3, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            step();
            chk("os3_tick", 32'(bif.SC_SPEEDTIMER_tick_Out), 32'(k == 3));
            chk("os3_done", 32'(bif.SC_SPEEDTIMER_done_Out), 32'(k >= 3));
        end
        do_load(2, 1'b1);
        chk("reload_done", 32'(bif.SC_SPEEDTIMER_done_Out), 32'd0);
        chk("reload_count", 32'(bif.SC_SPEEDTIMER_data_OutBUS), 32'd2);

        // Pause stretches N=5 by 3 cycles.
        do_load(5, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            bif.SC_SPEEDTIMER_enable_InLow = (k >= 3 && k <= 5);
            step();
            chk("pause_tick", 32'(bif.SC_SPEEDTIMER_tick_Out), 32'(k == 8));
        end
        bif.SC_SPEEDTIMER_enable_InLow = 1'b0;

        // Zero load stays idle.
        do_load(0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("zero_tick", 32'(bif.SC_SPEEDTIMER_tick_Out), 32'd0);
        end

        // N=1 periodic ticks every enabled cycle.
        do_load(1, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("n1_tick", 32'(bif.SC_SPEEDTIMER_tick_Out), 32'd1);
        end

        // Maximum period.
        do_load(255, 1'b1);
        first_tick = -1;
        for (int k = 1; k <= 256; k++) begin
            step();
            if (first_tick < 0 && bif.SC_SPEEDTIMER_tick_Out === 1'b1) first_tick = k;
        end
        chk("n255_first_tick", 32'(first_tick), 32'd255);

        // Load colliding with expiry suppresses the tick.
        do_load(2, 1'b1);
        step();
        bif.SC_SPEEDTIMER_data_InBUS = W'(6);
        bif.SC_SPEEDTIMER_load_InLow = 1'b0;
        step();
        bif.SC_SPEEDTIMER_load_InLow = 1'b1;
        chk("coll_tick", 32'(bif.SC_SPEEDTIMER_tick_Out), 32'd0);
        chk("coll_count", 32'(bif.SC_SPEEDTIMER_data_OutBUS), 32'd6);

        // Reset during a tick cycle drops the tick immediately.
        do_load(1, 1'b1);
        step();
        chk("pre_rst_tick", 32'(bif.SC_SPEEDTIMER_tick_Out), 32'd1);
        async_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bif.SC_SPEEDTIMER_enable_InLow  = ($urandom_range(0, 3) == 0);
            bif.SC_SPEEDTIMER_oneshot_InLow = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) begin
                bif.SC_SPEEDTIMER_data_InBUS = ($urandom_range(0, 5) == 0) ?
                    W'($urandom_range(0, 255)) : W'($urandom_range(0, 6));
                bif.SC_SPEEDTIMER_load_InLow = 1'b0;
            end
            step();
            bif.SC_SPEEDTIMER_load_InLow = 1'b1;
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
